// File: rtl/decoder_seq_if.sv
// decoder_seq_if -- control and status bundle for decoder_seq.
//   master : drives en, mode, load, w, dwell; observes y, idx, wrap
//   slave  : the decoder itself
interface decoder_seq_if #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
);
  logic               en;
  logic               mode;
  logic               load;
  logic [N-1:0]       w;
  logic [DWELL_W-1:0] dwell;
  logic [0:2**N-1]    y;
  logic [N-1:0]       idx;
  logic               wrap;

  modport master (
    output en, mode, load, w, dwell,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, load, w, dwell,
    output y, idx, wrap
  );
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq -- one-hot decoder with a direct-index mode and an
// auto-sweeping scan mode that holds each output for dwell+1 cycles.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : decoder_seq_if.slave (en, mode, load, w, dwell in;
//             y, idx, wrap out, all outputs registered)
//
// state  | meaning
// IDLE   | en=0: y blanked, idx and dwell counter hold
// DIRECT | en=1, mode=0: y decodes idx, idx changes only by load
// SCAN   | en=1, mode=1: idx steps every dwell+1 cycles
module decoder_seq #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
) (
  input logic           clk,
  input logic           reset_n,
  decoder_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             r_state;
  logic [N-1:0]       r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic [0:2**N-1]    r_y;
  logic               r_wrap;

  state_t             w_state_nxt;
  logic               w_step;
  logic [N-1:0]       w_idx_nxt;
  logic [0:2**N-1]    w_y_nxt;

  always_comb begin
    w_state_nxt = IDLE;
    if (bus.en) w_state_nxt = bus.mode ? SCAN : DIRECT;
  end

  // A step only happens when already scanning; entering SCAN restarts
  // the dwell count first. Load always overrides a step.
  assign w_step = (w_state_nxt == SCAN) && (r_state == SCAN) &&
                  (r_cnt == r_dwell) && !bus.load;

  always_comb begin
    w_idx_nxt = r_idx;
    if (bus.load)    w_idx_nxt = bus.w;
    else if (w_step) w_idx_nxt = r_idx + N'(1);
  end

  // y is built from next-state values so it lines up with idx.
  always_comb begin
    w_y_nxt = '0;
    for (int k = 0; k < 2**N; k++)
      w_y_nxt[k] = (w_state_nxt != IDLE) && (w_idx_nxt == N'(k));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_y     <= w_y_nxt;
      r_wrap  <= w_step && (r_idx == {N{1'b1}});
      if (bus.load) begin
        r_cnt   <= '0;
        r_dwell <= bus.dwell;
      end else if (w_state_nxt == SCAN) begin
        // dwell is only sampled when the counter restarts
        if (r_state != SCAN || r_cnt == r_dwell) begin
          r_cnt   <= '0;
          r_dwell <= bus.dwell;
        end else begin
          r_cnt <= r_cnt + DWELL_W'(1);
        end
      end
    end
  end

  assign bus.y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NY = 16;

  typedef struct {
    logic [0:NY-1] y;
    logic [N-1:0]  idx;
    logic          wrap;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  decoder_seq_if #(.N(N), .DWELL_W(DW)) bus ();
  decoder_seq #(.N(N), .DWELL_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: idx plus the number of cycles still to hold it.
  int m_idx  = 0;
  int m_hold = 0;
  bit m_scan = 0;

  function automatic logic [0:NY-1] onehot(int i);
    logic [0:NY-1] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_hold = 0;
    m_scan = 0;
  endtask

  // Drive inputs for the coming rising edge and predict its result.
  task automatic apply(bit en, bit mode, bit load, int w, int dwell);
    exp_t e;
    bit   wr;
    bus.en    = en;
    bus.mode  = mode;
    bus.load  = load;
    bus.w     = N'(w);
    bus.dwell = DW'(dwell);
    wr = 0;
    if (load) begin
      m_idx  = w;
      m_hold = dwell;
    end else if (en && mode) begin
      if (!m_scan) m_hold = dwell;
      else if (m_hold == 0) begin
        if (m_idx == NY - 1) wr = 1;
        m_idx  = (m_idx + 1) % NY;
        m_hold = dwell;
      end else m_hold--;
    end
    m_scan = en && mode;
    e.y    = en ? onehot(m_idx) : '0;
    e.idx  = N'(m_idx);
    e.wrap = wr;
    q.push_back(e);
  endtask

  task automatic drive(bit en, bit mode, bit load, int w, int dwell);
    @(negedge clk);
    apply(en, mode, load, w, dwell);
  endtask

  // Hold reset for some cycles with garbage inputs, release on a negedge.
  task automatic hold_and_release(int cycles, bit en, bit mode, int dwell);
    exp_t z;
    z.y = '0; z.idx = '0; z.wrap = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      bus.en    = 1'($urandom_range(0, 1));
      bus.mode  = 1'($urandom_range(0, 1));
      bus.load  = 1'($urandom_range(0, 1));
      bus.w     = N'($urandom_range(0, NY - 1));
      bus.dwell = DW'($urandom_range(0, 3));
      q.push_back(z);
    end
    @(negedge clk);
    reset_n = 1'b1;
    apply(en, mode, 0, 0, dwell);
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic async_reset(string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_y"},    32'(bus.y),    32'h0);
    chk({tag, "_idx"},  32'(bus.idx),  32'h0);
    chk({tag, "_wrap"}, 32'(bus.wrap), 32'h0);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("y",    32'(bus.y),    32'(mon_e.y));
      chk("idx",  32'(bus.idx),  32'(mon_e.idx));
      chk("wrap", 32'(bus.wrap), 32'(mon_e.wrap));
    end
  end

  initial begin
    bit r_en, r_mode;
    int r_dwell;
    reset_n   = 1'b1;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.load  = 1'b0;
    bus.w     = '0;
    bus.dwell = '0;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_y",    32'(bus.y),    32'h0);
    chk("rst_idx",  32'(bus.idx),  32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    hold_and_release(2, 0, 0, 0);

    // direct sweep
    for (int w = 0; w < NY; w++) begin
      drive(1, 0, 1, w, 0);
      repeat (4) drive(1, 0, 0, 0, 0);
    end

    // enable blanking with a load while blanked
    drive(1, 0, 1, 9, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // scan with dwell=2 from idx 14
    drive(1, 0, 1, 14, 0);
    repeat (12) drive(1, 1, 0, 0, 2);

    // scan with dwell=0, two full periods
    drive(1, 0, 1, 0, 0);
    repeat (40) drive(1, 1, 0, 0, 0);

    // load colliding with the 15->0 step
    drive(1, 0, 1, 13, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 7, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);

    // dwell change mid-dwell only takes effect at the next restart
    drive(1, 1, 1, 2, 3);
    drive(1, 1, 0, 0, 0);
    repeat (8) drive(1, 1, 0, 0, 1);

    // async reset mid-dwell at idx 11, then scan resumes from 0
    drive(1, 0, 1, 11, 0);
    drive(1, 1, 0, 0, 5);
    drive(1, 1, 0, 0, 5);
    async_reset("areset");
    hold_and_release(2, 1, 1, 0);
    repeat (6) drive(1, 1, 0, 0, 0);

    // randomized traffic
    r_en = 1; r_mode = 1; r_dwell = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        r_en   = ($urandom_range(0, 3) != 0);
        r_mode = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) r_dwell = $urandom_range(0, 3);
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd_reset");
        hold_and_release($urandom_range(0, 2), r_en, r_mode, r_dwell);
      end else begin
        drive(r_en, r_mode, ($urandom_range(0, 9) == 0),
              $urandom_range(0, NY - 1), r_dwell);
      end
    end

    drive(0, 0, 0, 0, 0);
    for (int t = 0; t < 5 && q.size() > 0; t++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter N, default 4: select width; decoder drives 2**N outputs.
REQ-002 Parameter DWELL_W, default 8: width of the scan dwell count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 en  input  1  output enable; 0 blanks y and freezes sequencing.
REQ-006 mode  input  1  0 = DIRECT (decode loaded index), 1 = SCAN (auto-sweep).
REQ-007 load  input  1  single-cycle strobe; captures w into the index register.
REQ-008 w  input  N  index to load.
REQ-009 dwell  input  DWELL_W  extra cycles each output is held in SCAN (0 = advance every cycle).
REQ-010 y  output  2**N  registered one-hot output, declared [0:2**N-1]; y[k] high selects index k.
REQ-011 idx  output  N  current index register value.
REQ-012 wrap  output  1  one-cycle pulse on the SCAN step from 2**N-1 to 0.

Function
REQ-013 The block SHALL contain a state machine with states IDLE, DIRECT, SCAN, re-evaluated every cycle.
REQ-014 State SHALL be IDLE when en=0, DIRECT when en=1 and mode=0, SCAN when en=1 and mode=1.
REQ-015 y SHALL equal one-hot of idx (only bit idx set) in DIRECT and SCAN, and all-zero in IDLE, registered with one cycle latency from the causing edge.
REQ-016 load=1 SHALL set idx=w on that edge in any state, including IDLE (idx updates; y stays zero while en=0).
REQ-017 In DIRECT, idx SHALL change only through load.
REQ-018 In SCAN, a DWELL_W-bit dwell counter SHALL count 0..dwell; at count==dwell idx SHALL increment by 1 modulo 2**N and the counter SHALL return to 0.
REQ-019 dwell SHALL be sampled at each counter restart; a change mid-dwell takes effect at the next step.
REQ-020 wrap SHALL be 1 for exactly the cycle after a SCAN step from idx=2**N-1 to 0, and 0 otherwise; load to 0 SHALL NOT assert wrap.
REQ-021 load and a SCAN step on the same edge: load SHALL win (idx=w, counter=0, no wrap).
REQ-022 Entering SCAN from any other state SHALL clear the dwell counter; idx is retained.
REQ-023 In IDLE the dwell counter and idx SHALL hold (except load per REQ-016).
REQ-024 Index arithmetic SHALL be N-bit unsigned with natural wrap; no output bit outside [0:2**N-1] exists.

Reset
REQ-025 reset_n=0 SHALL immediately, without a clock edge, force idx=0, y=all-zero, wrap=0, dwell counter=0, state IDLE.
REQ-026 Reset asserted mid-dwell or mid-scan SHALL discard all progress; after release, operation restarts from idx=0 at the first rising edge with reset_n=1.
REQ-027 Inputs SHALL be ignored while reset_n=0.

Verification (N=4, DWELL_W=8)
REQ-028 Direct sweep: en=1, mode=0, load w=0..15 one per 5 cycles -> y one-hot at bit w one cycle after each load (w=5 -> y=0000_0100_0000_0000), idx=w.
REQ-029 Enable blanking: DIRECT, idx=9, en=0 for 3 cycles with load w=3 -> y=0 throughout, idx=3; en=1 -> y[3]=1 next cycle.
REQ-030 Scan with dwell: mode=1, dwell=2, start idx=14 -> idx 14,14,14,15,15,15,0,... ; wrap=1 only in the cycle idx first reads 0.
REQ-031 Scan dwell=0: idx advances every cycle, full 16-cycle wrap period, wrap pulses once per 16 cycles.
REQ-032 Collision: SCAN, dwell=0, load w=7 on the edge where idx 15->0 would occur -> idx=7, wrap=0, following cycle idx=8.
REQ-033 Async reset: SCAN at idx=11, drop reset_n between edges -> y=0, idx=0, wrap=0 before next edge; release -> scan resumes from idx=0.
